// File: rtl/mult_seq_if.sv
// mult_seq_if: request/result bundle for the sequential multiplier.
// The master side issues start with operands a/b and observes busy/done and
// the 64-bit product split into prod_hi/prod_lo; the slave side is the
// multiplier itself.
interface mult_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;

  modport master (
    output start,
    output a,
    output b,
    input  busy,
    input  done,
    input  prod_hi,
    input  prod_lo
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output busy,
    output done,
    output prod_hi,
    output prod_lo
  );
endinterface

// File: rtl/mult_seq.sv
// mult_seq: 32x32 -> 64-bit unsigned multiplier, radix-2 shift-add, one
// partial-product step per clock (32 RUN cycles per operation).
//
// Optional feature, selected by the macro ZERO_BYPASS_EN:
//   defined   - a request with a zero operand skips RUN and goes straight to
//               DONE with a zero product (done one cycle after acceptance).
//   undefined - zero operands take the full 32-cycle path like any other pair.
//
// add32 is the shared 32-bit adder/ALU block; the multiplier uses exactly one
// instance of it in add mode, and its carry-out is the 33rd sum bit.

// ---------------------------------------------------------------------------
// add32: ripple-carry adder with a small op select.
//   ctrl 2'b00 : sum = a + b,  cout = carry out
//   ctrl 2'b01 : sum = a - b,  cout = no-borrow flag
//   ctrl 2'b10 : sum = a & b,  cout = 0
//   ctrl 2'b11 : sum = a ^ b,  cout = 0
// ---------------------------------------------------------------------------
module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  ctrl,
  output logic [31:0] sum,
  output logic        cout
);
  logic [32:0] carry;
  logic [31:0] b_eff;
  logic [31:0] raw_sum;

  // Subtraction is a + ~b + 1, so invert b and inject a carry for ctrl=01.
  assign b_eff    = (ctrl == 2'b01) ? ~b : b;
  assign carry[0] = (ctrl == 2'b01);

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_bit
      assign raw_sum[gi]   = a[gi] ^ b_eff[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b_eff[gi]) |
                             (a[gi] & carry[gi]) |
                             (b_eff[gi] & carry[gi]);
    end
  endgenerate

  // Result/carry select by operation.
  always_comb begin
    sum  = raw_sum;
    cout = carry[32];
    case (ctrl)
      2'b10: begin
        sum  = a & b;
        cout = 1'b0;
      end
      2'b11: begin
        sum  = a ^ b;
        cout = 1'b0;
      end
      default: begin
        sum  = raw_sum;
        cout = carry[32];
      end
    endcase
  end
endmodule

// ---------------------------------------------------------------------------
// mult_seq: control FSM plus M / P / cnt datapath.
// P holds {partial product, remaining multiplier bits}; each RUN cycle adds M
// into the upper half when P[0] is set, then shifts the 65-bit {c, s, P[31:1]}
// result right by one into P.
// ---------------------------------------------------------------------------
module mult_seq (
  input  logic        clk,
  input  logic        rst,
  mult_seq_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] m_reg;
  logic [31:0] m_next;
  logic [63:0] p_reg;
  logic [63:0] p_next;
  logic [5:0]  cnt_reg;
  logic [5:0]  cnt_next;

  logic [31:0] addend;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        zero_operand;

  // When the current multiplier bit is 0 the adder adds zero, so
  // {cout, sum} is simply {1'b0, P[63:32]}.
  assign addend = p_reg[0] ? m_reg : 32'h0000_0000;

  add32 u_add (
    .a    (p_reg[63:32]),
    .b    (addend),
    .ctrl (2'b00),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign zero_operand = (bus.a == 32'h0000_0000) || (bus.b == 32'h0000_0000);

  // FSM state register; reset acts immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers; reset clears everything at once so the outputs read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg   <= 32'h0000_0000;
      p_reg   <= 64'h0;
      cnt_reg <= 6'd0;
    end else begin
      m_reg   <= m_next;
      p_reg   <= p_next;
      cnt_reg <= cnt_next;
    end
  end

  // Next-state and next-datapath logic; every register holds by default.
  always_comb begin
    state_next = state_reg;
    m_next     = m_reg;
    p_next     = p_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE: begin
        // Operands are captured only here, so later changes on a/b and any
        // start seen in RUN or DONE have no effect.
        if (bus.start) begin
          m_next   = bus.a;
          cnt_next = 6'd0;
`ifdef ZERO_BYPASS_EN
          if (zero_operand) begin
            p_next     = 64'h0;
            state_next = DONE;
          end else begin
            p_next     = {32'h0000_0000, bus.b};
            state_next = RUN;
          end
`else
          p_next     = {32'h0000_0000, bus.b};
          state_next = RUN;
`endif
        end
      end

      RUN: begin
        p_next   = {add_cout, add_sum, p_reg[31:1]};
        cnt_next = cnt_reg + 6'd1;
        // cnt counts completed steps; the step taken with cnt=31 is the 32nd.
        if (cnt_reg == 6'd31) begin
          state_next = DONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifndef ZERO_BYPASS_EN
  // Without the bypass the zero test has no consumer; fold it into a
  // harmless term so the net is still considered used.
  logic unused_zero;
  assign unused_zero = zero_operand & 1'b0;
`endif

  // Status flags come straight from the state register.
  assign bus.busy    = (state_reg == RUN);
  assign bus.done    = (state_reg == DONE);
  assign bus.prod_hi = p_reg[63:32];
  assign bus.prod_lo = p_reg[31:0];
endmodule
